// File: rtl/bcd_range_counter_if.sv
// bcd_range_counter_if: count control, load request and status of one BCD counter stage.
interface bcd_range_counter_if #(parameter int DIGITS = 2);
  logic en;
  logic up;
  logic load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd;
  logic cout;
  logic load_err;
  modport master (output en, up, load, load_val, input bcd, cout, load_err);
  modport slave (input en, up, load, load_val, output bcd, cout, load_err);
endinterface

// File: rtl/bcd_range_counter.sv
// bcd_range_counter: cascadable packed-BCD up/down counter over [MIN_VAL, MAX_VAL]
// with validated synchronous load and combinational terminal-count carry.
module bcd_range_counter #(
  parameter int DIGITS = 2,
  parameter logic [4*DIGITS-1:0] MIN_VAL = 'h01,
  parameter logic [4*DIGITS-1:0] MAX_VAL = 'h12,
  parameter logic [4*DIGITS-1:0] RST_VAL = 'h12
) (
  input logic clk,
  input logic rst_n,
  bcd_range_counter_if.slave bus
);
  localparam int W = 4*DIGITS;

  function automatic logic digits_ok(input logic [W-1:0] v);
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) digits_ok = digits_ok & (v[4*i+:4] <= 4'd9);
  endfunction

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_range_counter: DIGITS must be 1..4");
  end
  if (!digits_ok(MIN_VAL) || !digits_ok(MAX_VAL) || !digits_ok(RST_VAL)) begin : g_bad_bcd
    $error("bcd_range_counter: parameter holds a non-BCD nibble");
  end
  if (MIN_VAL > MAX_VAL) begin : g_bad_range
    $error("bcd_range_counter: MIN_VAL exceeds MAX_VAL");
  end
  if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("bcd_range_counter: RST_VAL outside range");
  end

  logic [W-1:0] inc, dec, nxt;
  logic cy, bw, at_max, at_min, load_ok;

  // Ripple carry/borrow through the digits; a digit only changes while the chain is live.
  always_comb begin
    inc = bus.bcd;
    dec = bus.bcd;
    cy = 1'b1;
    bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = cy ? (bus.bcd[4*i+:4] == 4'd9 ? 4'd0 : bus.bcd[4*i+:4] + 4'd1) : bus.bcd[4*i+:4];
      dec[4*i+:4] = bw ? (bus.bcd[4*i+:4] == 4'd0 ? 4'd9 : bus.bcd[4*i+:4] - 4'd1) : bus.bcd[4*i+:4];
      cy = cy & (bus.bcd[4*i+:4] == 4'd9);
      bw = bw & (bus.bcd[4*i+:4] == 4'd0);
    end
  end

  assign at_max = bus.bcd == MAX_VAL;
  assign at_min = bus.bcd == MIN_VAL;
  assign load_ok = digits_ok(bus.load_val) && bus.load_val >= MIN_VAL && bus.load_val <= MAX_VAL;
  assign bus.cout = bus.en & ~bus.load & (bus.up ? at_max : at_min);
  assign nxt = bus.load ? (load_ok ? bus.load_val : bus.bcd) :
               !bus.en  ? bus.bcd :
               bus.up   ? (at_max ? MIN_VAL : inc) :
                          (at_min ? MAX_VAL : dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bcd <= RST_VAL;
      bus.load_err <= 1'b0;
    end else begin
      bus.bcd <= nxt;
      bus.load_err <= bus.load & ~load_ok;
    end
  end
endmodule
